// File: rtl/ir_index_conditioner.sv
// ir_index_conditioner: synchronizes and debounces the raw IR break-beam, rejects early trips,
// and reports index pulses, revolution period and rotor stall.
module ir_index_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int MIN_PERIOD      = 1_000_000,
    parameter int STALL_CYCLES    = 50_000_000,
    parameter int PERIOD_WIDTH    = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    ir_raw,
    output logic                    ir_tripped,
    output logic                    index_pulse,
    output logic [PERIOD_WIDTH-1:0] period_out,
    output logic                    period_valid,
    output logic                    stalled,
    output logic [7:0]              glitch_count
);
    localparam int                      CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]           DB    = CW'(DEBOUNCE_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] MINP  = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] STALP = PERIOD_WIDTH'(STALL_CYCLES);

    typedef enum logic [1:0] {S_LOW, S_CONF_H, S_HIGH, S_CONF_L} state_t;

    logic [SYNC_STAGES-1:0]  r_sync;
    state_t                  r_state, w_next;
    logic [CW-1:0]           r_cnt, w_cnt_next;
    logic [PERIOD_WIDTH-1:0] r_since;
    logic                    r_armed;
    logic                    w_sync, w_rise, w_fall, w_accept, w_reject, w_stall;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sync  <= '0;
            r_state <= S_LOW;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], ir_raw};
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_LOW: if (w_sync) begin
                w_next     = S_CONF_H;
                w_cnt_next = CW'(1);
            end
            S_CONF_H: begin
                w_next     = !w_sync ? S_LOW : (r_cnt == DB ? S_HIGH : S_CONF_H);
                w_cnt_next = (!w_sync || r_cnt == DB) ? '0 : r_cnt + 1'b1;
            end
            S_HIGH: if (!w_sync) begin
                w_next     = S_CONF_L;
                w_cnt_next = CW'(1);
            end
            S_CONF_L: begin
                w_next     = w_sync ? S_HIGH : (r_cnt == DB ? S_LOW : S_CONF_L);
                w_cnt_next = (w_sync || r_cnt == DB) ? '0 : r_cnt + 1'b1;
            end
            default: begin
                w_next     = S_LOW;
                w_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        w_rise   = (r_state == S_CONF_H) && w_sync && (r_cnt == DB);
        w_fall   = (r_state == S_CONF_L) && !w_sync && (r_cnt == DB);
        w_accept = w_rise && (!r_armed || r_since >= MINP);
        w_reject = w_rise && !w_accept;
        w_stall  = r_since >= STALP;
    end

    // since_last holds the elapsed count during a commit cycle, then restarts at 1
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_since      <= '0;
            r_armed      <= 1'b0;
            ir_tripped   <= 1'b0;
            index_pulse  <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
            glitch_count <= '0;
        end else begin
            r_since      <= w_accept ? PERIOD_WIDTH'(1) : ((&r_since) ? r_since : r_since + 1'b1);
            r_armed      <= w_accept ? 1'b1 : (w_stall ? 1'b0 : r_armed);
            stalled      <= w_accept ? 1'b0 : (w_stall ? 1'b1 : stalled);
            ir_tripped   <= w_accept ? 1'b1 : (w_fall ? 1'b0 : ir_tripped);
            index_pulse  <= w_accept;
            period_valid <= w_accept && r_armed;
            period_out   <= (w_accept && r_armed) ? r_since : period_out;
            glitch_count <= (w_reject && glitch_count != 8'hFF) ? glitch_count + 1'b1 : glitch_count;
        end
    end
endmodule

// File: doc/ir_index_conditioner.md
Name: ir_index_conditioner

Overview:
Front end that produces the clean ir_tripped level consumed by the rotation-angle tracker.
- Takes the raw, asynchronous IR break-beam sensor line and synchronizes and debounces it.
- Rejects spurious trips that arrive too soon after the previous one.
- Emits a one-cycle index pulse and the measured revolution period per accepted trip, and flags a stalled or absent rotor.

Parameters:
SYNC_STAGES, 2, synchronizer flop depth (>=2)
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to commit a level change (>=1)
MIN_PERIOD, 1_000_000, minimum cycles between accepted trips; rising edges earlier than this are glitches
STALL_CYCLES, 50_000_000, cycles without an accepted trip before stalled asserts (> MIN_PERIOD)
PERIOD_WIDTH, 32, width of period counter/output

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  asynchronous, active-high reset
ir_raw  input  1  raw sensor line, high = beam broken, asynchronous to clk_in
ir_tripped  output  1  debounced, accepted trip level
index_pulse  output  1  one-cycle pulse on each accepted rising commit
period_out  output  PERIOD_WIDTH  cycles between the last two accepted commits
period_valid  output  1  one-cycle pulse when period_out updates
stalled  output  1  no accepted trip for STALL_CYCLES cycles
glitch_count  output  8  saturating count of rejected rising commits

Behaviour:
- Reset (async assert, deassert sampled on clk_in):
  - All synchronizer flops 0.
  - FSM in LOW, debounce counter 0, since_last 0.
  - ir_tripped, index_pulse, period_valid, stalled all 0; period_out 0; glitch_count 0.
  - armed=0, meaning the next accepted trip produces no period.
- Synchronizer: ir_raw passes through SYNC_STAGES flops; only the last stage (sync) is used.
- Debounce FSM, states LOW, CONFIRM_HIGH, HIGH, CONFIRM_LOW:
  - LOW: if sync=1, go to CONFIRM_HIGH with cnt=1.
  - CONFIRM_HIGH: if sync=0, return to LOW and clear cnt. Otherwise, if cnt==DEBOUNCE_CYCLES, perform the rising commit and go to HIGH. Otherwise cnt++.
  - HIGH / CONFIRM_LOW: mirror image of LOW / CONFIRM_HIGH. The falling commit in CONFIRM_LOW drives ir_tripped low if it was high.
- Latency: a clean, steady ir_raw rise is committed exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first clk_in edge that samples it high. Falls have the same latency.
- since_last counter:
  - Increments every cycle and saturates at all-ones.
  - Is set to 1 in the cycle after an accepted commit, so the commit cycle itself holds the elapsed count.
- Rising commit is accepted if armed=0 OR since_last >= MIN_PERIOD. On acceptance:
  - ir_tripped <= 1 and index_pulse pulses.
  - since_last restarts.
  - stalled <= 0 and armed <= 1.
  - If armed was 1, period_out <= since_last and period_valid pulses in the same cycle as index_pulse.
- Rising commit is rejected otherwise. On rejection:
  - glitch_count++, saturating at 255.
  - ir_tripped stays 0; the FSM still moves to HIGH, so the matching fall is consumed silently.
  - since_last is not reset.
- Stall: when since_last reaches STALL_CYCLES (and the cycle is not an accepted commit), stalled <= 1 and armed <= 0. The first trip after a stall gives index_pulse but no period_valid.
- Simultaneous stall threshold and accepted commit: the commit wins (stalled stays/returns 0).
- Outputs are registered; index_pulse and period_valid are never high for two consecutive cycles.
- Reset mid-debounce or mid-rotation discards all state immediately (asynchronous).

Test Plan:
Common setup: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, MIN_PERIOD=100, STALL_CYCLES=1000, PERIOD_WIDTH=16, unless stated.
1. Clean pulses: after reset, ir_raw high for 20 cycles every 300 cycles, 4 revolutions.
   - ir_tripped rises 6 cycles after each ir_raw rise.
   - index_pulse x4.
   - period_valid x3, each with period_out=300.
   - glitch_count=0.
2. Bounce: ir_raw toggles 1,0,1,0 on single cycles, then holds high.
   - Exactly one commit, 6 cycles after the final rise.
   - No index_pulse during the bounce.
3. Early trip: clean trips at t=0, t=300, plus a 10-cycle pulse at t=350.
   - The t=350 pulse is rejected: glitch_count=1, ir_tripped stays 0.
   - The next trip at t=600 gives period_out=300.
4. Stall: one trip, then ir_raw held low for 1200 cycles.
   - stalled=1 at 1000 cycles after the commit.
   - The next trip clears stalled, pulses index_pulse, and gives no period_valid.
   - The following trip 300 cycles later gives period_out=300.
5. Async reset asserted mid-CONFIRM_HIGH and between trips.
   - All outputs 0 immediately, without waiting for a clock edge.
   - After release, the first trip produces no period_valid.
6. Saturation: 300 rejected glitch pulses → glitch_count holds at 255.
